// File: rtl/hack_pkg.sv
// hack_pkg: shared types and instruction-field constants for the Hack control core.
// States, IR field positions, destination bit indices and jump codes.
package hack_pkg;

    // Sequencer states; HALT is only reachable when HACK_CTRL_HALT_EN is defined
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_COMMIT = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Instruction word field positions
    localparam int C_BIT   = 15;
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    // Bit indices inside the 3-bit dest field (d1 d2 d3)
    localparam int DST_A = 2;
    localparam int DST_D = 1;
    localparam int DST_M = 0;

    // Jump codes (j1 j2 j3)
    localparam logic [2:0] J_NULL = 3'b000;
    localparam logic [2:0] JGT    = 3'b001;
    localparam logic [2:0] JEQ    = 3'b010;
    localparam logic [2:0] JGE    = 3'b011;
    localparam logic [2:0] JLT    = 3'b100;
    localparam logic [2:0] JNE    = 3'b101;
    localparam logic [2:0] JLE    = 3'b110;
    localparam logic [2:0] JMP    = 3'b111;

    // True for a C-instruction; the two bits below the opcode are don't-care
    function automatic logic is_c_inst(input logic [15:0] ir);
        return ir[C_BIT];
    endfunction

endpackage

// File: rtl/hack_jump_cond.sv
// hack_jump_cond: combinational jump decision from the jump field and the
// registered ALU flags. Each code is the OR of the selected lt/eq/gt terms,
// written out so that inconsistent flag pairs (zr=ng=1) behave as the
// plain sum-of-terms would.
module hack_jump_cond
    import hack_pkg::*;
(
    input  logic [2:0] jump,
    input  logic       zr,
    input  logic       ng,
    output logic       jmp
);

    logic gt;

    assign gt = ~ng & ~zr;

    // Decode the jump code against the lt (ng), eq (zr) and gt terms
    always_comb begin
        jmp = 1'b0;
        case (jump)
            J_NULL:  jmp = 1'b0;
            JGT:     jmp = gt;
            JEQ:     jmp = zr;
            JGE:     jmp = zr | gt;
            JLT:     jmp = ng;
            JNE:     jmp = ng | gt;
            JLE:     jmp = ng | zr;
            JMP:     jmp = ng | zr | gt;
            default: jmp = 1'b0;
        endcase
    end

endmodule

// File: rtl/hack_ctrl.sv
// hack_ctrl: multi-cycle sequencer for the Hack CPU. Owns A, D, PC and IR,
// fetches over a req/valid handshake, accesses data memory over req/ack and
// drives the external combinational ALU.
// Optional build macro HACK_CTRL_HALT_EN: a taken unconditional jump onto
// itself parks the core in HALT with halted=1 until reset.
module hack_ctrl
    import hack_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [DW-1:0] imem_data,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    output logic          alu_zx,
    output logic          alu_nx,
    output logic          alu_zy,
    output logic          alu_ny,
    output logic          alu_f,
    output logic          alu_no,
    input  logic [DW-1:0] alu_o,
    input  logic          alu_zr,
    input  logic          alu_ng,
    output logic [AW-1:0] pc,
    output logic          halted
);

    // The instruction encoding only makes sense for a 16-bit word
    if (DW != 16) begin : g_dw_check
        $error("hack_ctrl: DW must be 16");
    end

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] ir;
    logic [DW-1:0] m;
    logic [DW-1:0] r;
    logic          zr;
    logic          ng;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_inc;
    logic [2:0]    dest;
    logic [2:0]    jump;
    logic          jmp;

    assign pc_inc = pc_q + AW'(1);
    assign dest   = ir[DEST_HI:DEST_LO];
    assign jump   = ir[JUMP_HI:JUMP_LO];
    assign pc     = pc_q;

    hack_jump_cond u_jump_cond (
        .jump (jump),
        .zr   (zr),
        .ng   (ng),
        .jmp  (jmp)
    );

`ifdef HACK_CTRL_HALT_EN
    logic halt_hit;
    logic halted_q;

    // A taken JMP whose target is the instruction itself is a deliberate stop
    assign halt_hit = jmp && (jump == JMP) && (a[AW-1:0] == pc_q);
    assign halted   = halted_q;

    // Halt flag sets on the self-loop commit and clears only on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else if (state == ST_COMMIT && halt_hit) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

    // Datapath-facing outputs: addresses and operands follow the registers
    assign imem_addr  = pc_q;
    assign dmem_addr  = a[AW-1:0];
    assign dmem_wdata = r;
    assign alu_x      = d;
    assign alu_y      = ir[A_BIT] ? m : a;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[COMP_HI:COMP_LO];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake requests; requests are masked while reset is high
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!is_c_inst(ir)) begin
                    state_nxt = ST_FETCH;
                end else if (ir[A_BIT]) begin
                    state_nxt = ST_MEM_RD;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_MEM_RD: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = dest[DST_M] ? ST_MEM_WR : ST_COMMIT;
            end
            ST_MEM_WR: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (dmem_ack) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_FETCH;
`ifdef HACK_CTRL_HALT_EN
                if (halt_hit) begin
                    state_nxt = ST_HALT;
                end
`endif
            end
`ifdef HACK_CTRL_HALT_EN
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
`endif
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
        end
    end

    // Architectural registers: IR on fetch, A/PC on A-instructions, PC/A/D on commit
    always_ff @(posedge clk) begin
        if (reset) begin
            a    <= '0;
            d    <= '0;
            pc_q <= '0;
            ir   <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir <= imem_data;
                    end
                end
                ST_DECODE: begin
                    if (!is_c_inst(ir)) begin
                        a    <= ir;
                        pc_q <= pc_inc;
                    end
                end
                ST_COMMIT: begin
                    // Jump target uses A before this instruction's own A update
                    pc_q <= jmp ? a[AW-1:0] : pc_inc;
                    if (dest[DST_A]) begin
                        a <= r;
                    end
                    if (dest[DST_D]) begin
                        d <= r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operand and result latches; only meaningful within the owning instruction
    always_ff @(posedge clk) begin
        if (state == ST_MEM_RD && dmem_ack) begin
            m <= dmem_rdata;
        end
        if (state == ST_EXEC) begin
            r  <= alu_o;
            zr <= alu_zr;
            ng <= alu_ng;
        end
    end

endmodule

// File: tb/tb_hack_ctrl.sv
// tb_hack_ctrl: directed bench for hack_ctrl with a zero-wait instruction ROM,
// a data RAM with programmable ack delay and a behavioural Hack ALU.
module tb_hack_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_o;
    logic        alu_zr;
    logic        alu_ng;
    logic [14:0] pc;
    logic        halted;

    logic [5:0]  ctl;
    logic [15:0] imem [0:63];
    logic [15:0] dmem [0:127];

    int tests = 0;
    int fails = 0;

    int ack_delay = 0;
    int wait_cnt = 0;
    logic        init_we = 1'b0;
    logic [6:0]  init_addr = '0;
    logic [15:0] init_data = '0;

    int rq_starts = 0;
    int rq_cycles = 0;
    int stab_err = 0;
    int ifetch_cycles = 0;
    logic        prev_rq = 1'b0;
    logic [14:0] last_addr = '0;
    logic        last_we = 1'b0;
    logic [15:0] last_wdata = '0;

    hack_ctrl #(.AW(15), .DW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_zx     (alu_zx),
        .alu_nx     (alu_nx),
        .alu_zy     (alu_zy),
        .alu_ny     (alu_ny),
        .alu_f      (alu_f),
        .alu_no     (alu_no),
        .alu_o      (alu_o),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Reference Hack ALU
    function automatic logic [15:0] alu_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic [5:0] c);
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign ctl        = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
    assign alu_o      = alu_model(alu_x, alu_y, ctl);
    assign alu_zr     = (alu_o == 16'h0000);
    assign alu_ng     = alu_o[15];
    assign imem_valid = imem_req;
    assign imem_data  = imem[imem_addr[5:0]];
    assign dmem_rdata = dmem[dmem_addr[6:0]];
    assign dmem_ack   = dmem_req && (wait_cnt >= ack_delay);

    // Data RAM: preload port plus DUT writes; ack counter per request
    always @(posedge clk) begin
        if (init_we) begin
            dmem[init_addr] <= init_data;
        end else if (dmem_req && dmem_we && dmem_ack) begin
            dmem[dmem_addr[6:0]] <= dmem_wdata;
        end
        if (!dmem_req || dmem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    // Request monitor: counts requests, records their attributes, flags instability
    always @(negedge clk) begin
        prev_rq <= dmem_req;
        if (dmem_req) begin
            rq_cycles <= rq_cycles + 1;
            if (!prev_rq) begin
                rq_starts  <= rq_starts + 1;
                last_addr  <= dmem_addr;
                last_we    <= dmem_we;
                last_wdata <= dmem_wdata;
            end else if (dmem_addr !== last_addr || dmem_we !== last_we ||
                         (dmem_we && dmem_wdata !== last_wdata)) begin
                stab_err <= stab_err + 1;
            end
        end
        if (imem_req) ifetch_cycles <= ifetch_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [6:0] ad, input logic [15:0] da);
        init_addr = ad;
        init_data = da;
        init_we   = 1'b1;
        @(posedge clk);
        #1;
        init_we   = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    endtask

    // Hold reset (already high) for two edges, then release mid-cycle
    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_pc(input logic [14:0] tgt, input int budget, input string tag);
        int n;
        n = 0;
        while (pc !== tgt && n < budget) begin
            step();
            n++;
        end
        check(tag, pc, tgt);
    endtask

    task automatic wait_pc_ne(input logic [14:0] from, input int budget);
        int n;
        n = 0;
        while (pc === from && n < budget) begin
            step();
            n++;
        end
    endtask

    int snap_rq;
    int snap_cyc;
    int snap_stab;
    int snap_if;
    int n;

    initial begin
        clear_imem();
        for (int i = 0; i < 128; i++) dmem[i] = 16'h0000;

        // Reset state and A-instruction / D=A
        imem[0] = 16'h0005;
        imem[1] = 16'hEC10;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        snap_rq = rq_starts;
        reset = 1'b0;
        #1;
        check("rel_imem_req", imem_req, 1);
        check("rel_imem_addr", imem_addr, 0);
        check("rel_A", dmem_addr, 0);
        check("rel_D", alu_x, 0);
        step();
        check("ainst_pc_hold", pc, 0);
        step();
        check("ainst_pc", pc, 1);
        check("ainst_A", dmem_addr, 5);
        step();
        step();
        check("dea_exec_ctl", ctl, 6'b110000);
        check("dea_exec_y", alu_y, 16'd5);
        step();
        step();
        check("dea_pc", pc, 2);
        check("dea_D", alu_x, 16'd5);
        check("dea_no_dreq", rq_starts - snap_rq, 0);

        // M=D+1 with ack delayed 3 cycles
        reset = 1'b1;
        imem[2] = 16'h0064;
        imem[3] = 16'hE7C8;
        ack_delay = 3;
        release_reset();
        snap_rq = rq_starts;
        snap_cyc = rq_cycles;
        snap_stab = stab_err;
        wait_pc(15'd4, 80, "wr_pc");
        check("wr_nreq", rq_starts - snap_rq, 1);
        check("wr_held", rq_cycles - snap_cyc, 4);
        check("wr_we", last_we, 1);
        check("wr_addr", last_addr, 100);
        check("wr_wdata", last_wdata, 16'd6);
        check("wr_stable", stab_err - snap_stab, 0);
        check("wr_mem", dmem[100], 16'd6);
        check("wr_D_keep", alu_x, 16'd5);

        // D=M read, then D;JLT taken on a negative value
        reset = 1'b1;
        clear_imem();
        imem[0] = 16'h0064;
        imem[1] = 16'hFC10;
        imem[2] = 16'h0007;
        imem[3] = 16'hE304;
        ack_delay = 1;
        poke(7'd100, 16'h8000);
        release_reset();
        wait_pc(15'd2, 40, "rd_pc");
        check("rd_D", alu_x, 16'h8000);
        check("rd_we", last_we, 0);
        check("rd_addr", last_addr, 100);
        wait_pc(15'd3, 40, "jlt_pc3");
        wait_pc_ne(15'd3, 40);
        check("jlt_taken", pc, 7);

        // Same program with a positive value: falls through
        reset = 1'b1;
        poke(7'd100, 16'h0001);
        release_reset();
        wait_pc(15'd3, 60, "jlt2_pc3");
        check("jlt2_D", alu_x, 16'h0001);
        wait_pc_ne(15'd3, 40);
        check("jlt_not_taken", pc, 4);

        // Reset pulse while waiting in MEM_WR
        reset = 1'b1;
        clear_imem();
        imem[0] = 16'h0005;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0064;
        imem[3] = 16'hE7C8;
        ack_delay = 20;
        poke(7'd100, 16'h1234);
        release_reset();
        n = 0;
        while (!(dmem_req && dmem_we) && n < 60) begin
            step();
            n++;
        end
        check("abort_wr_seen", dmem_req && dmem_we, 1);
        step();
        step();
        reset = 1'b1;
        #1;
        check("abort_req_masked", dmem_req, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_dreq", dmem_req, 0);
        check("abort_pc", pc, 0);
        check("abort_A", dmem_addr, 0);
        check("abort_D", alu_x, 0);
        check("abort_fetch", imem_req, 1);
        check("abort_faddr", imem_addr, 0);
        check("abort_mem", dmem[100], 16'h1234);
        wait_pc(15'd1, 10, "abort_restart_pc");
        check("abort_restart_A", dmem_addr, 5);
        ack_delay = 0;

        // Self-loop 0;JMP at address 3
        reset = 1'b1;
        clear_imem();
        imem[2] = 16'h0003;
        imem[3] = 16'hEA87;
        release_reset();
        wait_pc(15'd3, 40, "loop_pc3");
        repeat (12) step();
        snap_if = ifetch_cycles;
        repeat (10) step();
        check("loop_pc", pc, 3);
`ifdef HACK_CTRL_HALT_EN
        check("halt_flag", halted, 1);
        check("halt_no_fetch", ifetch_cycles - snap_if, 0);
`else
        check("nohalt_flag", halted, 0);
        check("nohalt_fetching", (ifetch_cycles - snap_if) >= 2, 1);
`endif

        // PC wrap from 2^15-1 to 0
        reset = 1'b1;
        clear_imem();
        imem[0]  = 16'h7FFF;
        imem[1]  = 16'hEA87;
        imem[63] = 16'h0009;
        release_reset();
        wait_pc(15'h7FFF, 40, "wrap_top");
        wait_pc_ne(15'h7FFF, 20);
        check("wrap_pc", pc, 0);
        check("wrap_A", dmem_addr, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hack_ctrl.md
Name: hack_ctrl

Overview:
- Multi-cycle sequencer for the Hack 16-bit ALU.
- Owns the A, D and PC registers and fetches instructions from instruction memory over a req/valid handshake.
- Decodes A- and C-instructions, drives the ALU operands and control bits, and reads or writes data memory over a req/ack handshake.
- Sits between the instruction ROM, the data RAM and the combinational ALU, and forms the control core of the Hack CPU.

Parameters:
- AW, 15, address width of PC, A-as-address, imem_addr and dmem_addr.
- DW, 16, data/instruction width (fixed for Hack; checked by assertion).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch address (= PC).
- imem_valid  in  1  imem_data is valid this cycle.
- imem_data  in  DW  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  AW  A[AW-1:0].
- dmem_wdata  out  DW  ALU result.
- dmem_rdata  in  DW  read data, valid with dmem_ack.
- dmem_ack  in  1  access complete.
- alu_x, alu_y  out  DW  x = D; y = (a-bit ? M : A).
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  copies of IR[11:6].
- alu_o  in  DW  ALU result.
- alu_zr, alu_ng  in  1  ALU flags.
- pc  out  AW  current PC.
- halted  out  1  halt flag (see Optional Feature).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On reset:
  - A=D=PC=IR=0, state=FETCH, halted=0.
  - imem_req, dmem_req and dmem_we are forced 0 while reset is high.
- States: FETCH, DECODE, MEM_RD, EXEC, MEM_WR, COMMIT, HALT.
- FETCH:
  - imem_req=1, imem_addr=PC, held stable until imem_valid.
  - imem_valid is accepted in the same cycle as the request (zero-wait ROM is legal).
  - On valid, IR<=imem_data and go to DECODE. imem_valid is ignored outside FETCH.
- DECODE:
  - IR[15]=0 (A-instruction): A<=IR, PC<=PC+1, go to FETCH.
  - IR[15]=1 (C-instruction, IR[14:13] ignored): go to MEM_RD if IR[12]=1, else to EXEC.
- MEM_RD:
  - dmem_req=1, we=0, addr=A, held until dmem_ack.
  - On ack, M<=dmem_rdata and go to EXEC.
- EXEC:
  - ALU inputs are driven; R<=alu_o, ZR<=alu_zr, NG<=alu_ng.
  - Next state is MEM_WR if d3 (IR[3]), else COMMIT.
- MEM_WR:
  - dmem_req=1, we=1, addr=A (the old A), wdata=R, held until ack.
  - Exactly one request per instruction; go to COMMIT on ack.
- COMMIT:
  - Jump condition is evaluated on the pre-update A: jmp = (j1&NG) | (j2&ZR) | (j3&~NG&~ZR).
  - PC <= jmp ? A_old[AW-1:0] : PC+1.
  - Then, in the same cycle: if d1, A<=R; if d2, D<=R.
  - Go to FETCH.
- ALU control outputs are driven from IR in all states, and alu_y is muxed by IR[12]. Outside EXEC they are don't-care for bench checks.
- PC increments wrap from 2^AW-1 to 0.
- Zero-wait latency:
  - A-instruction: 2 cycles.
  - C-instruction with no memory access: 4 cycles.
  - Each memory access adds 1 cycle plus ack wait.
- Reset in any state (including mid-handshake) aborts the instruction with no register update. Fetch restarts from 0 on the first cycle after reset deasserts.
- An ack/valid arriving without a request is ignored.

Optional Feature:
- Macro: HACK_CTRL_HALT_EN.
- Defined:
  - In COMMIT, if jmp=1, j=3'b111 and the target equals the current PC, set halted=1 and go to HALT.
  - HALT issues no requests; halted and PC hold until reset.
- Undefined: no HALT state, halted tied 0, and the self-loop executes forever.

Decomposition:
- Package hack_pkg holds:
  - state enum;
  - IR field positions (A_BIT=12, COMP=11:6, DEST=5:3, JUMP=2:0);
  - dest bit indices;
  - jump code constants (JGT=001 … JMP=111).
- One natural sub-module: hack_jump_cond, a combinational evaluation of (jump bits, ZR, NG) to jmp.

Test Plan:
- Reset, then imem[0]=0x0005 with zero-wait ROM: A=5 and PC=1 two cycles after reset release, with no dmem_req.
- 0x0005 then 0xEC10 (D=A): alu_zx..no=110000 in EXEC, D=5, PC=2, dmem_req never asserted.
- A=100, D=5, 0xE7C8 (M=D+1) with ack delayed 3 cycles: a single dmem_req, we=1, addr=100, wdata=6, held stable until ack, PC+1.
- A=100, mem[100]=0x8000, 0xFC10 (D=M): read at addr 100, D=0x8000. Then @7 and 0xE304 (D;JLT) gives PC=7. With D=0x0001, PC increments instead.
- Reset pulsed for one cycle while waiting in MEM_WR: dmem_req=0 the next cycle, A/D/PC=0, fetch from addr 0 follows.
- HACK_CTRL_HALT_EN defined, imem[2]=0x0003, imem[3]=0xEA87 (0;JMP): halted=1 with PC=3 and no further imem_req. With the macro undefined, PC loops at 3.
